// File: rtl/cell_seq_pkg.sv
// Shared types and constants for the select/toggle cell operation sequencer.
package cell_seq_pkg;

  typedef enum logic {
    OP_TOGGLE = 1'b0,
    OP_AND    = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_e;

  // S value that, with A=B=0, makes every cell reload its own q.
  localparam logic HOLD_S = 1'b0;

endpackage

// File: rtl/cell_op_sequencer.sv
// Accepts one cell-bank operation per handshake, drives S/A/B for the
// requested number of cycles, then freezes the bank and captures its value.
module cell_op_sequencer
  import cell_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             cell_s,
  output logic [WIDTH-1:0] cell_a,
  output logic [WIDTH-1:0] cell_b,
  input  logic [WIDTH-1:0] cell_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state;
  op_e              op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] eff_len;

  // A zero length runs once, which also keeps the down-counter from wrapping.
  always_comb begin
    eff_len = cmd_len;
    if (cmd_len == '0) begin
      eff_len = CNT_W'(1);
    end
  end

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_r   <= OP_TOGGLE;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      cell_s <= HOLD_S;
      cell_a <= '0;
      cell_b <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_r   <= op_e'(cmd_op);
            a_r    <= cmd_a;
            b_r    <= cmd_b;
            cnt    <= eff_len;
            cell_s <= cmd_op;
            cell_a <= cmd_a;
            cell_b <= cmd_op ? cmd_b : '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          // Drive outputs are registered, so the hold code must be loaded
          // on the last RUN edge to appear exactly in CAPT.
          if (cnt == CNT_W'(1)) begin
            cell_s <= HOLD_S;
            cell_a <= '0;
            cell_b <= '0;
            state  <= CAPT;
          end else begin
            cnt    <= cnt - CNT_W'(1);
            cell_s <= (op_r == OP_AND);
            cell_a <= a_r;
            cell_b <= (op_r == OP_AND) ? b_r : '0;
          end
        end

        CAPT: begin
          result <= cell_q;
          done   <= 1'b1;
          state  <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          cell_s <= HOLD_S;
          cell_a <= '0;
          cell_b <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_op_sequencer.sv
// Randomized self-checking bench for cell_op_sequencer with an inline cell bank.
module tb_cell_op_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int NRAND = 30;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [CNT_W-1:0] cmd_len;
  logic             cell_s;
  logic [WIDTH-1:0] cell_a;
  logic [WIDTH-1:0] cell_b;
  logic [WIDTH-1:0] cell_q;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] bank;
  logic [WIDTH-1:0] model_q;
  logic [WIDTH-1:0] model_result;
  int               check_count;
  int               error_count;

  cell_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_len   (cmd_len),
    .cell_s    (cell_s),
    .cell_a    (cell_a),
    .cell_b    (cell_b),
    .cell_q    (cell_q),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The select/toggle cell bank: S=1 loads A&B, S=0 loads A^q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else begin
      bank <= cell_s ? (cell_a & cell_b) : (cell_a ^ bank);
    end
  end
  assign cell_q = bank;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, actual, expected);
    end
  endtask

  // Issues one command at an IDLE negedge and follows it cycle by cycle to
  // the next IDLE cycle; with chain set, the next command is offered (valid
  // high) for the whole busy period.
  task automatic applyStimulus(input logic op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [CNT_W-1:0] len,
                               input bit chain, input logic nop,
                               input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                               input logic [CNT_W-1:0] nlen);
    int runs;
    logic [WIDTH-1:0] exp_q;
    runs = (len == 0) ? 1 : int'(len);
    if (op) exp_q = a & b;
    else    exp_q = (runs % 2 == 1) ? (model_q ^ a) : model_q;

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_len   = len;
    checkOutput("idle_ready", 32'(cmd_ready), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    if (chain) begin
      cmd_op  = nop;
      cmd_a   = na;
      cmd_b   = nb;
      cmd_len = nlen;
    end else begin
      cmd_valid = 1'b0;
      cmd_op    = 1'($urandom);
      cmd_a     = WIDTH'($urandom);
      cmd_b     = WIDTH'($urandom);
      cmd_len   = CNT_W'($urandom);
    end
    for (int i = 0; i < runs; i++) begin
      checkOutput("run_s", 32'(cell_s), 32'(op));
      checkOutput("run_a", 32'(cell_a), 32'(a));
      checkOutput("run_b", 32'(cell_b), op ? 32'(b) : 32'd0);
      checkOutput("run_ready", 32'(cmd_ready), 32'd0);
      checkOutput("run_busy", 32'(busy), 32'd1);
      checkOutput("run_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    checkOutput("capt_hold", {cell_s, 8'h00, cell_a, cell_b}, 32'd0);
    checkOutput("capt_done", 32'(done), 32'd0);
    checkOutput("capt_result", 32'(result), 32'(model_result));
    checkOutput("capt_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_result", 32'(result), 32'(exp_q));
    checkOutput("done_q", 32'(cell_q), 32'(exp_q));
    checkOutput("done_ready", 32'(cmd_ready), 32'd0);
    model_q      = exp_q;
    model_result = exp_q;
    @(negedge clk);
    checkOutput("post_done", 32'(done), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_ready", 32'(cmd_ready), 32'd1);
    checkOutput("post_result", 32'(result), 32'(model_result));
  endtask

  logic             r_op  [NRAND];
  logic [WIDTH-1:0] r_a   [NRAND];
  logic [WIDTH-1:0] r_b   [NRAND];
  logic [CNT_W-1:0] r_len [NRAND];

  initial begin
    check_count  = 0;
    error_count  = 0;
    model_q      = '0;
    model_result = '0;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = 1'b0;
    cmd_a        = '0;
    cmd_b        = '0;
    cmd_len      = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_hold", {cell_s, 8'h00, cell_a, cell_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed commands");
    applyStimulus(1'b0, 8'hFF, 8'h00, 4'd3, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
    applyStimulus(1'b1, 8'hF0, 8'h3C, 4'd1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
    applyStimulus(1'b0, 8'h0F, 8'hAA, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);

    $display("[TB] back-to-back commands with valid held high");
    applyStimulus(1'b0, 8'h55, 8'h12, 4'd2, 1'b1, 1'b1, 8'hFF, 8'h3F, 4'd4);
    applyStimulus(1'b1, 8'hFF, 8'h3F, 4'd4, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);

    $display("[TB] idle hold with wiggling command fields");
    for (int i = 0; i < 20; i++) begin
      checkOutput("idle_q", 32'(cell_q), 32'(model_q));
      checkOutput("idle_hold", {cell_s, 8'h00, cell_a, cell_b}, 32'd0);
      checkOutput("idle_result", 32'(result), 32'(model_result));
      checkOutput("idle_busy_hold", 32'(busy), 32'd0);
      cmd_valid = 1'b0;
      cmd_op    = 1'($urandom);
      cmd_a     = WIDTH'($urandom);
      cmd_b     = WIDTH'($urandom);
      cmd_len   = CNT_W'($urandom);
      @(negedge clk);
    end

    $display("[TB] reset in the middle of a run");
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_a     = 8'hA5;
    cmd_b     = 8'h00;
    cmd_len   = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_result", 32'(result), 32'd0);
    checkOutput("mrst_q", 32'(cell_q), 32'd0);
    checkOutput("mrst_hold", {cell_s, 8'h00, cell_a, cell_b}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("mrst_done", 32'(done), 32'd0);
    end
    rst_n        = 1'b1;
    model_q      = '0;
    model_result = '0;
    @(negedge clk);
    checkOutput("mrst_done_after", 32'(done), 32'd0);
    applyStimulus(1'b0, 8'h3C, 8'h00, 4'd1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);

    $display("[TB] randomized commands");
    for (int i = 0; i < NRAND; i++) begin
      r_op[i]  = 1'($urandom);
      r_a[i]   = WIDTH'($urandom);
      r_b[i]   = WIDTH'($urandom);
      r_len[i] = CNT_W'($urandom_range(0, 15));
    end
    r_len[0] = 4'd15;
    r_len[1] = 4'd0;
    for (int i = 0; i < NRAND; i++) begin
      if (i < NRAND - 1 && $urandom_range(0, 1) == 1) begin
        applyStimulus(r_op[i], r_a[i], r_b[i], r_len[i], 1'b1,
                      r_op[i+1], r_a[i+1], r_b[i+1], r_len[i+1]);
      end else begin
        applyStimulus(r_op[i], r_a[i], r_b[i], r_len[i], 1'b0,
                      1'b0, '0, '0, '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
